// File: rtl/vic_pkg.sv
// Shared constants for the vectored interrupt controller: register word map,
// source-mode encoding and ID/priority field sizing.
package vic_pkg;
    localparam int unsigned MAX_SRC     = 32;
    localparam int unsigned PRIO_FW     = 4;
    localparam int unsigned ID_W        = 6;

    localparam int unsigned W_ENABLE    = 0;
    localparam int unsigned W_PENDING   = 1;
    localparam int unsigned W_CLEAR     = 2;
    localparam int unsigned W_STATUS    = 3;
    localparam int unsigned W_MODE      = 4;
    localparam int unsigned W_THRESH    = 5;
    localparam int unsigned W_CLAIM     = 6;
    localparam int unsigned W_INSERVICE = 7;
    localparam int unsigned W_PRIO0     = 8;

    typedef enum logic {LEVEL = 1'b0, EDGE = 1'b1} mode_e;
endpackage

// File: rtl/vectored_intr_controller_if.sv
// CPU register-bus bundle for the interrupt controller; slave side is the controller.
interface vectored_intr_controller_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) ();
    logic                  cpu_read;
    logic                  cpu_write;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0] cpu_write_data;
    logic [DATA_WIDTH-1:0] cpu_read_data;
    logic                  cpu_access_complete;
    logic                  cpu_irq;

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_write_data,
        input  cpu_read_data, cpu_access_complete, cpu_irq
    );
    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_write_data,
        output cpu_read_data, cpu_access_complete, cpu_irq
    );
endinterface

// File: rtl/vic_arbiter.sv
// Picks the highest-priority candidate (lowest ID on ties) and registers the
// winning ID and the interrupt request derived from it.
module vic_arbiter
    import vic_pkg::*;
#(
    parameter int NUM_SRC    = 16,
    parameter int PRIO_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_SRC-1:0]                   cand_i,
    input  logic [NUM_SRC-1:0][PRIO_WIDTH-1:0]   prio_i,
    output logic [ID_W-1:0]                      best_id_o,
    output logic                                 irq_o
);
    logic [ID_W-1:0]       id_d, id_q;
    logic [PRIO_WIDTH-1:0] prio_d;
    logic                  irq_q;

    // Candidates always carry prio > 0, so a strict compare keeps the lowest ID on ties.
    always_comb begin
        id_d   = '0;
        prio_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand_i[i] && (prio_i[i] > prio_d)) begin
                id_d   = ID_W'(i + 1);
                prio_d = prio_i[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            id_q  <= id_d;
            irq_q <= (id_d != '0);
        end
    end

    assign best_id_o = id_q;
    assign irq_o     = irq_q;
endmodule

// File: rtl/vectored_intr_controller.sv
// Vectored interrupt controller: synchronisers, per-source pending/in-service state,
// register file and claim/complete handshake. VIC_PREEMPT_EN enables nested preemption.
module vectored_intr_controller
    import vic_pkg::*;
#(
    parameter int NUM_SRC    = 16,
    parameter int PRIO_WIDTH = 3,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   ext_intr,
    vectored_intr_controller_if.slave bus
);
    logic [NUM_SRC-1:0]                 s1_q, s2_q, s3_q, en_q, mode_q;
    logic [NUM_SRC-1:0]                 pend, insv, cand, inject, clr, cmplt;
    logic [NUM_SRC-1:0][PRIO_WIDTH-1:0] prio;
    logic [PRIO_WIDTH-1:0]              thr_q, eff_thr;
    logic [ID_W-1:0]                    best_id;
    logic                               irq, wr, rd, claim;
    logic [31:0]                        widx;
    logic [DATA_WIDTH-1:0]              rdata_d, rdata_q;
    logic                               cmpl_q;

    assign widx   = 32'(bus.cpu_address[ADDR_WIDTH-1:2]);
    assign wr     = bus.cpu_write;
    assign rd     = bus.cpu_read & ~bus.cpu_write;
    assign claim  = rd && (widx == W_CLAIM) && (best_id != '0);
    assign inject = (wr && widx == W_PENDING) ? bus.cpu_write_data[NUM_SRC-1:0] : '0;
    assign clr    = (wr && widx == W_CLEAR)   ? bus.cpu_write_data[NUM_SRC-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= ext_intr;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic                  pnd_q, isv_q, is_edge, set, drop, hit;
        logic [PRIO_WIDTH-1:0] pr_q;

        assign is_edge  = (mode_e'(mode_q[i]) == EDGE);
        assign hit      = claim && (best_id == ID_W'(i + 1));
        assign cmplt[i] = wr && (widx == W_CLAIM) && (bus.cpu_write_data == DATA_WIDTH'(i + 1));
        assign set      = inject[i] | (is_edge ? (s2_q[i] & ~s3_q[i]) : s2_q[i]);
        // A level source withdraws its request when the line falls.
        assign drop     = clr[i] | hit | (~is_edge & ~s2_q[i] & s3_q[i]);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pnd_q <= 1'b0;
                isv_q <= 1'b0;
                pr_q  <= '0;
            end else begin
                pnd_q <= set | (pnd_q & ~drop);
                isv_q <= (isv_q | hit) & ~cmplt[i];
                if (wr && widx == W_PRIO0 + i / 8)
                    pr_q <= bus.cpu_write_data[(i % 8) * PRIO_FW +: PRIO_WIDTH];
            end
        end

        assign pend[i] = pnd_q;
        assign insv[i] = isv_q;
        assign prio[i] = pr_q;
        assign cand[i] = pnd_q & en_q[i] & ~isv_q & (pr_q > eff_thr);
    end

`ifdef VIC_PREEMPT_EN
    always_comb begin
        eff_thr = thr_q;
        for (int i = 0; i < NUM_SRC; i++)
            if (insv[i] && prio[i] > eff_thr) eff_thr = prio[i];
    end
`else
    assign eff_thr = thr_q;
`endif

    vic_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_WIDTH(PRIO_WIDTH)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .cand_i    (cand),
        .prio_i    (prio),
        .best_id_o (best_id),
        .irq_o     (irq)
    );

    always_comb begin
        rdata_d = '0;
        case (widx)
            W_ENABLE:    rdata_d[NUM_SRC-1:0]    = en_q;
            W_PENDING:   rdata_d[NUM_SRC-1:0]    = pend;
            W_STATUS:    rdata_d[NUM_SRC-1:0]    = s2_q;
            W_MODE:      rdata_d[NUM_SRC-1:0]    = mode_q;
            W_THRESH:    rdata_d[PRIO_WIDTH-1:0] = thr_q;
            W_CLAIM:     rdata_d[ID_W-1:0]       = best_id;
            W_INSERVICE: rdata_d[NUM_SRC-1:0]    = insv;
            default:     rdata_d                 = '0;
        endcase
        for (int i = 0; i < NUM_SRC; i++)
            if (widx == W_PRIO0 + 32'(i / 8))
                rdata_d[(i % 8) * PRIO_FW +: PRIO_WIDTH] = prio[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= '0;
            mode_q  <= '0;
            thr_q   <= '0;
            rdata_q <= '0;
            cmpl_q  <= 1'b0;
        end else begin
            if (wr && widx == W_ENABLE) en_q   <= bus.cpu_write_data[NUM_SRC-1:0];
            if (wr && widx == W_MODE)   mode_q <= bus.cpu_write_data[NUM_SRC-1:0];
            if (wr && widx == W_THRESH) thr_q  <= bus.cpu_write_data[PRIO_WIDTH-1:0];
            if (rd) rdata_q <= rdata_d;
            cmpl_q <= bus.cpu_read | bus.cpu_write;
        end
    end

    assign bus.cpu_read_data       = rdata_q;
    assign bus.cpu_access_complete = cmpl_q;
    assign bus.cpu_irq             = irq;
endmodule
